// File: rtl/mdu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mdu_pkg : shared encodings and decode helpers for mdu_seq32         |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package mdu_pkg;

    localparam logic [2:0] MDU_MUL    = 3'd0;
    localparam logic [2:0] MDU_MULH   = 3'd1;
    localparam logic [2:0] MDU_MULHSU = 3'd2;
    localparam logic [2:0] MDU_MULHU  = 3'd3;
    localparam logic [2:0] MDU_DIV    = 3'd4;
    localparam logic [2:0] MDU_DIVU   = 3'd5;
    localparam logic [2:0] MDU_REM    = 3'd6;
    localparam logic [2:0] MDU_REMU   = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_CALC = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    function automatic logic is_div(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic in1_signed(input logic [2:0] op);
        return (op == MDU_MULH) || (op == MDU_MULHSU) || (op == MDU_DIV) || (op == MDU_REM);
    endfunction

    function automatic logic in2_signed(input logic [2:0] op);
        return (op == MDU_MULH) || (op == MDU_DIV) || (op == MDU_REM);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_step32.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mdu_step32 : one radix-2 shift-add / restoring-divide iteration     |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module mdu_step32
    import mdu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]        op,
    input  logic [2*XLEN-1:0] acc,
    input  logic [XLEN-1:0]   opnd,
    output logic [2*XLEN-1:0] acc_next
);

    logic [XLEN:0] w_sum;
    logic [XLEN:0] w_rem_shift;
    logic [XLEN:0] w_diff;

    assign w_sum       = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, opnd};
    // remainder after the left shift needs 33 bits before the trial subtract
    assign w_rem_shift = acc[2*XLEN-1:XLEN-1];
    assign w_diff      = w_rem_shift - {1'b0, opnd};

    always_comb begin
        acc_next = acc;
        if (is_div(op)) begin
            if (!w_diff[XLEN]) begin
                acc_next = {w_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
            end else begin
                acc_next = {w_rem_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
            end
        end else begin
            if (acc[0]) begin
                acc_next = {w_sum, acc[XLEN-1:1]};
            end else begin
                acc_next = {1'b0, acc[2*XLEN-1:1]};
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mdu_seq32.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mdu_seq32 : iterative RV32M multiply/divide sequencer               |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module mdu_seq32
    import mdu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] in1,
    input  logic [XLEN-1:0] in2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out,
    output logic            busy
);

    localparam logic [XLEN-1:0] c_int_min = {1'b1, {(XLEN-1){1'b0}}};

    state_e              state_q, state_d;
    logic [2:0]          op_q, op_d;
    logic [XLEN-1:0]     in1_q, in1_d;
    logic [XLEN-1:0]     in2_q, in2_d;
    logic [XLEN-1:0]     out_q, out_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                neg_q, neg_d;

    logic                w_div, w_s1, w_s2, w_div_zero, w_ovf;
    logic [XLEN-1:0]     w_abs1, w_abs2, w_result;
    logic [2*XLEN-1:0]   w_acc_step, w_acc_neg;

    assign w_div      = is_div(op_q);
    assign w_s1       = in1_signed(op_q) & in1_q[XLEN-1];
    assign w_s2       = in2_signed(op_q) & in2_q[XLEN-1];
    assign w_abs1     = w_s1 ? (~in1_q + 1'b1) : in1_q;
    assign w_abs2     = w_s2 ? (~in2_q + 1'b1) : in2_q;
    assign w_div_zero = (in2_q == '0);
    assign w_ovf      = ((op_q == MDU_DIV) || (op_q == MDU_REM)) &&
                        (in1_q == c_int_min) && (in2_q == '1);
    assign w_acc_neg  = ~acc_q + 1'b1;

    // in2_q holds the raw rs2 until PREP, then the iteration operand
    mdu_step32 #(.XLEN(XLEN)) u_step (
        .op       (op_q),
        .acc      (acc_q),
        .opnd     (in2_q),
        .acc_next (w_acc_step)
    );

    always_comb begin
        w_result = acc_q[XLEN-1:0];
        case (op_q)
            MDU_MUL:                         w_result = acc_q[XLEN-1:0];
            MDU_MULH, MDU_MULHSU, MDU_MULHU: w_result = neg_q ? w_acc_neg[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
            MDU_DIV, MDU_DIVU:               w_result = neg_q ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
            default:                         w_result = neg_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        in1_d   = in1_q;
        in2_d   = in2_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        out_d   = out_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && !flush) begin
                    op_d    = op;
                    in1_d   = in1;
                    in2_d   = in2;
                    state_d = ST_PREP;
                end
            end
            ST_PREP: begin
                neg_d = (w_div && op_q[1]) ? w_s1 : (w_s1 ^ w_s2);
                if (w_div && w_div_zero) begin
                    out_d   = op_q[1] ? in1_q : '1;
                    state_d = ST_DONE;
                end else if (w_ovf) begin
                    out_d   = op_q[1] ? '0 : c_int_min;
                    state_d = ST_DONE;
                end else begin
                    in2_d   = w_div ? w_abs2 : w_abs1;
                    acc_d   = {{XLEN{1'b0}}, (w_div ? w_abs1 : w_abs2)};
                    cnt_d   = '0;
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                acc_d = w_acc_step;
                cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                if (cnt_q == {CNT_W{1'b1}}) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                out_d   = w_result;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            in1_q   <= '0;
            in2_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            in1_q   <= in1_d;
            in2_q   <= in2_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            out_q   <= out_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign out       = out_q;

endmodule
`default_nettype wire

// File: tb/tb_mdu_seq32.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_mdu_seq32 : directed self-checking bench for mdu_seq32           |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_mdu_seq32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  op = 3'd0;
    logic [31:0] in1 = 32'd0;
    logic [31:0] in2 = 32'd0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mdu_seq32 #(.XLEN(32), .CNT_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .in1       (in1),
        .in2       (in2),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .busy      (busy)
    );

    // Issue one request and wait (bounded) for out_valid; lat counts cycles after T, -1 on timeout.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat);
        op = o; in1 = a; in2 = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; in1 = 32'hDEAD_BEEF; in2 = 32'h1234_5678; op = 3'd7;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) lat = -1;
        res = out;
    endtask

    task automatic accept();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out !== 32'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset: in_ready=%b out_valid=%b out=%h busy=%b required 1 0 00000000 0",
                     in_ready, out_valid, out, busy);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic run_table(input string name, input logic [2:0] t_op [4], input logic [31:0] t_a [4],
                             input logic [31:0] t_b [4], input logic [31:0] t_exp [4], input int exp_lat);
        logic [31:0] res;
        int lat;
        for (int i = 0; i < 4; i++) begin
            run_op(t_op[i], t_a[i], t_b[i], res, lat);
            checks++;
            if (res !== t_exp[i]) begin
                errors++;
                $display("FAIL %s[%0d] result: got %h required %h", name, i, res, t_exp[i]);
            end
            checks++;
            if (lat != exp_lat) begin
                errors++;
                $display("FAIL %s[%0d] latency: got %0d required %0d", name, i, lat, exp_lat);
            end
            accept();
        end
    endtask

    task automatic test_mul();
        logic [2:0]  t_op [4] = '{3'd0, 3'd1, 3'd3, 3'd2};
        logic [31:0] t_a  [4] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] t_b  [4] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'd2};
        logic [31:0] t_e  [4] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
        run_table("mul", t_op, t_a, t_b, t_e, 35);
    endtask

    task automatic test_div();
        logic [2:0]  t_op [4] = '{3'd4, 3'd6, 3'd5, 3'd7};
        logic [31:0] t_a  [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
        logic [31:0] t_b  [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
        logic [31:0] t_e  [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
        run_table("div", t_op, t_a, t_b, t_e, 35);
    endtask

    task automatic test_special();
        logic [2:0]  t_op [4] = '{3'd5, 3'd6, 3'd4, 3'd6};
        logic [31:0] t_a  [4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] t_b  [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] t_e  [4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
        run_table("special", t_op, t_a, t_b, t_e, 2);
    endtask

    task automatic test_backpressure();
        logic [31:0] res;
        int lat;
        run_op(3'd0, 32'd6, 32'd7, res, lat);
        checks++;
        if (res !== 32'd42 || lat != 35) begin
            errors++;
            $display("FAIL bp_result: got %h lat %0d required 0000002a lat 35", res, lat);
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || out !== 32'd42 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: out_valid=%b out=%h in_ready=%b required 1 0000002a 0",
                         i, out_valid, out, in_ready);
            end
        end
        accept();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_flush();
        bit seen = 1'b0;
        op = 3'd5; in1 = 32'd100; in2 = 32'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle: busy=%b in_ready=%b out_valid=%b required 0 1 0",
                     busy, in_ready, out_valid);
        end
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL flush_no_result: out_valid seen=1 required 0");
        end
        in_valid = 1'b1; flush = 1'b1; op = 3'd0; in1 = 32'd1; in2 = 32'd1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_blocks_accept: busy=%b in_ready=%b required 0 1", busy, in_ready);
        end
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] res;
        int lat;
        op = 3'd0; in1 = 32'd9; in2 = 32'd9; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out !== 32'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_op: in_ready=%b out_valid=%b out=%h busy=%b required 1 0 00000000 0",
                     in_ready, out_valid, out, busy);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        run_op(3'd0, 32'd3, 32'd4, res, lat);
        checks++;
        if (res !== 32'd12 || lat != 35) begin
            errors++;
            $display("FAIL mul_after_reset: got %h lat %0d required 0000000c lat 35", res, lat);
        end
        accept();
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_backpressure();
        test_flush();
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
